// File: rtl/sram_bus_responder.sv
// sram_bus_responder: responder end of a 16-bit asynchronous SRAM bus.
// Bus strobes are synchronised into the clock domain. Half-word writes are
// paired into 32-bit word writes. Reads fetch a whole word into a one-word
// buffer, and A0 selects the returned half combinationally.
module sram_bus_responder #(
  parameter int ASIZE = 18,
  parameter int SYNC  = 2
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic             bus_cs_b,
  input  logic             bus_oe_b,
  input  logic             bus_we_b,
  input  logic [ASIZE-1:0] bus_addr,
  input  logic [15:0]      bus_data_in,
  output logic [15:0]      bus_data_out,
  output logic             bus_data_oe,
  output logic             mem_req,
  output logic             mem_rnw,
  output logic [ASIZE-2:0] mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [1:0]       mem_wmask,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack,
  output logic             overflow
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  // One bus event: a half-word write (wr=1) or a word read (wr=0).
  typedef struct packed {
    logic             wr;
    logic             a0;
    logic [ASIZE-2:0] waddr;
    logic [15:0]      data;
  } ev_t;

  // Merge the enabled halves of a write word into an existing word.
  function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [1:0]  mask);
    logic [31:0] res;
    res = old_word;
    if (mask[1]) res[31:16] = new_word[31:16];
    if (mask[0]) res[15:0]  = new_word[15:0];
    return res;
  endfunction

  // Synchroniser and aligned address/data pipeline.
  logic [SYNC-1:0]  cs_sync_r, oe_sync_r, we_sync_r;
  logic [ASIZE-1:0] addr_pipe_r [SYNC];
  logic [15:0]      data_pipe_r [SYNC];

  logic             cs_s, oe_s, we_s, rd_act_s;
  logic [ASIZE-1:0] addr_s;
  logic [15:0]      data_s;
  logic             we_prev_r, rd_act_prev_r;
  logic [ASIZE-2:0] waddr_prev_r;
  logic             wr_ev_s, rd_ev_s;
  ev_t              wr_in_s, rd_in_s;

  // Control state.
  state_t           state_r;
  ev_t              slot_r;
  logic             slot_valid_r;
  logic             low_pending_r;
  logic [ASIZE-2:0] low_addr_r;
  logic [15:0]      low_data_r;
  logic [31:0]      buf_r;
  logic [ASIZE-2:0] buf_addr_r;
  logic             buf_valid_r;
  logic             nxt_valid_r, nxt_rnw_r;
  logic [ASIZE-2:0] nxt_addr_r;
  logic [31:0]      nxt_wdata_r;
  logic [1:0]       nxt_wmask_r;

  // Event arbitration and operation decode.
  ev_t              cur_s, store_s;
  logic             cur_valid_s, store_valid_s, drop_s;
  logic             iss_s, iss_rnw_s;
  logic [ASIZE-2:0] iss_addr_s;
  logic [31:0]      iss_wdata_s;
  logic [1:0]       iss_wmask_s;
  logic             nxt_set_s, nxt_rnw_s;
  logic [31:0]      nxt_wdata_s;
  logic [1:0]       nxt_wmask_s;
  logic             lp_set_s, lp_clr_s;

  // Shift strobes (reset inactive-high) and the aligned addr/data samples.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      cs_sync_r <= '1;
      oe_sync_r <= '1;
      we_sync_r <= '1;
      for (int i = 0; i < SYNC; i++) begin
        addr_pipe_r[i] <= '0;
        data_pipe_r[i] <= 16'h0000;
      end
    end else begin
      cs_sync_r      <= {cs_sync_r[SYNC-2:0], bus_cs_b};
      oe_sync_r      <= {oe_sync_r[SYNC-2:0], bus_oe_b};
      we_sync_r      <= {we_sync_r[SYNC-2:0], bus_we_b};
      addr_pipe_r[0] <= bus_addr;
      data_pipe_r[0] <= bus_data_in;
      for (int i = 1; i < SYNC; i++) begin
        addr_pipe_r[i] <= addr_pipe_r[i-1];
        data_pipe_r[i] <= data_pipe_r[i-1];
      end
    end
  end

  assign cs_s     = cs_sync_r[SYNC-1];
  assign oe_s     = oe_sync_r[SYNC-1];
  assign we_s     = we_sync_r[SYNC-1];
  assign addr_s   = addr_pipe_r[SYNC-1];
  assign data_s   = data_pipe_r[SYNC-1];
  assign rd_act_s = !(cs_s | oe_s);

  // Remember previous synced values for edge and address-change detection.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      we_prev_r     <= 1'b1;
      rd_act_prev_r <= 1'b0;
      waddr_prev_r  <= '0;
    end else begin
      we_prev_r     <= we_s;
      rd_act_prev_r <= rd_act_s;
      waddr_prev_r  <= addr_s[ASIZE-1:1];
    end
  end

  assign wr_ev_s = we_s & !we_prev_r & !cs_s;
  assign rd_ev_s = rd_act_s & (!rd_act_prev_r | (addr_s[ASIZE-1:1] != waddr_prev_r));
  assign wr_in_s = {1'b1, addr_s[0], addr_s[ASIZE-1:1], data_s};
  assign rd_in_s = {1'b0, addr_s[0], addr_s[ASIZE-1:1], 16'h0000};

  // Pick the event to execute now, the one to park in the slot, and drops.
  // A write always goes ahead of a read arriving in the same cycle.
  always_comb begin
    cur_valid_s   = 1'b0;
    cur_s         = slot_r;
    store_valid_s = 1'b0;
    store_s       = wr_in_s;
    drop_s        = 1'b0;
    if (state_r == ST_IDLE) begin
      if (slot_valid_r) begin
        cur_valid_s = 1'b1;
        cur_s       = slot_r;
        if (wr_ev_s) begin
          store_valid_s = 1'b1;
          store_s       = wr_in_s;
          drop_s        = rd_ev_s;
        end else if (rd_ev_s) begin
          store_valid_s = 1'b1;
          store_s       = rd_in_s;
        end else begin
          store_valid_s = 1'b0;
        end
      end else if (wr_ev_s) begin
        cur_valid_s   = 1'b1;
        cur_s         = wr_in_s;
        store_valid_s = rd_ev_s;
        store_s       = rd_in_s;
      end else if (rd_ev_s) begin
        cur_valid_s = 1'b1;
        cur_s       = rd_in_s;
      end else begin
        cur_valid_s = 1'b0;
      end
    end else begin
      if (slot_valid_r) begin
        drop_s = wr_ev_s | rd_ev_s;
      end else if (wr_ev_s) begin
        store_valid_s = 1'b1;
        store_s       = wr_in_s;
        drop_s        = rd_ev_s;
      end else if (rd_ev_s) begin
        store_valid_s = 1'b1;
        store_s       = rd_in_s;
      end else begin
        drop_s = 1'b0;
      end
    end
  end

  // Decode the current event into a memory transaction, an optional
  // follow-up transaction (after a flush of the held low half) and
  // updates of the held low half.
  always_comb begin
    iss_s       = 1'b0;
    iss_rnw_s   = 1'b0;
    iss_addr_s  = cur_s.waddr;
    iss_wdata_s = 32'h0000_0000;
    iss_wmask_s = 2'b00;
    nxt_set_s   = 1'b0;
    nxt_rnw_s   = 1'b0;
    nxt_wdata_s = 32'h0000_0000;
    nxt_wmask_s = 2'b00;
    lp_set_s    = 1'b0;
    lp_clr_s    = 1'b0;
    if (cur_valid_s) begin
      if (cur_s.wr && !cur_s.a0) begin
        lp_set_s = 1'b1;
        if (low_pending_r && (low_addr_r != cur_s.waddr)) begin
          iss_s       = 1'b1;
          iss_addr_s  = low_addr_r;
          iss_wdata_s = {16'h0000, low_data_r};
          iss_wmask_s = 2'b01;
        end else begin
          iss_s = 1'b0;
        end
      end else if (cur_s.wr) begin
        lp_clr_s = 1'b1;
        if (low_pending_r && (low_addr_r == cur_s.waddr)) begin
          iss_s       = 1'b1;
          iss_wdata_s = {cur_s.data, low_data_r};
          iss_wmask_s = 2'b11;
        end else if (low_pending_r) begin
          iss_s       = 1'b1;
          iss_addr_s  = low_addr_r;
          iss_wdata_s = {16'h0000, low_data_r};
          iss_wmask_s = 2'b01;
          nxt_set_s   = 1'b1;
          nxt_wdata_s = {cur_s.data, 16'h0000};
          nxt_wmask_s = 2'b10;
        end else begin
          iss_s       = 1'b1;
          iss_wdata_s = {cur_s.data, 16'h0000};
          iss_wmask_s = 2'b10;
        end
      end else begin
        if (buf_valid_r && (buf_addr_r == cur_s.waddr)) begin
          iss_s = 1'b0;
        end else if (low_pending_r) begin
          lp_clr_s    = 1'b1;
          iss_s       = 1'b1;
          iss_addr_s  = low_addr_r;
          iss_wdata_s = {16'h0000, low_data_r};
          iss_wmask_s = 2'b01;
          nxt_set_s   = 1'b1;
          nxt_rnw_s   = 1'b1;
        end else begin
          iss_s     = 1'b1;
          iss_rnw_s = 1'b1;
        end
      end
    end else begin
      iss_s = 1'b0;
    end
  end

  // Main FSM: event slot, held low half, memory handshake and read buffer.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_r       <= ST_IDLE;
      mem_req       <= 1'b0;
      mem_rnw       <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= 32'h0000_0000;
      mem_wmask     <= 2'b00;
      overflow      <= 1'b0;
      slot_r        <= '0;
      slot_valid_r  <= 1'b0;
      low_pending_r <= 1'b0;
      low_addr_r    <= '0;
      low_data_r    <= 16'h0000;
      buf_r         <= 32'h0000_0000;
      buf_addr_r    <= '0;
      buf_valid_r   <= 1'b0;
      nxt_valid_r   <= 1'b0;
      nxt_rnw_r     <= 1'b0;
      nxt_addr_r    <= '0;
      nxt_wdata_r   <= 32'h0000_0000;
      nxt_wmask_r   <= 2'b00;
    end else begin
      overflow <= overflow | drop_s;
      if (store_valid_s) begin
        slot_r       <= store_s;
        slot_valid_r <= 1'b1;
      end else if (state_r == ST_IDLE) begin
        slot_valid_r <= 1'b0;
      end
      if (lp_set_s) begin
        low_pending_r <= 1'b1;
        low_addr_r    <= cur_s.waddr;
        low_data_r    <= cur_s.data;
      end else if (lp_clr_s) begin
        low_pending_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (iss_s) begin
            mem_req     <= 1'b1;
            mem_rnw     <= iss_rnw_s;
            mem_addr    <= iss_addr_s;
            mem_wdata   <= iss_wdata_s;
            mem_wmask   <= iss_wmask_s;
            state_r     <= iss_rnw_s ? ST_READ : ST_WRITE;
            nxt_valid_r <= nxt_set_s;
            nxt_rnw_r   <= nxt_rnw_s;
            nxt_addr_r  <= cur_s.waddr;
            nxt_wdata_r <= nxt_wdata_s;
            nxt_wmask_r <= nxt_wmask_s;
            if (!iss_rnw_s && buf_valid_r && (buf_addr_r == iss_addr_s)) begin
              buf_r <= merge_word(buf_r, iss_wdata_s, iss_wmask_s);
            end
          end
        end
        ST_WRITE: begin
          if (mem_ack) begin
            if (nxt_valid_r) begin
              // Follow-up transaction goes out with no idle cycle.
              mem_rnw     <= nxt_rnw_r;
              mem_addr    <= nxt_addr_r;
              mem_wdata   <= nxt_wdata_r;
              mem_wmask   <= nxt_wmask_r;
              nxt_valid_r <= 1'b0;
              state_r     <= nxt_rnw_r ? ST_READ : ST_WRITE;
              if (!nxt_rnw_r && buf_valid_r && (buf_addr_r == nxt_addr_r)) begin
                buf_r <= merge_word(buf_r, nxt_wdata_r, nxt_wmask_r);
              end
            end else begin
              mem_req <= 1'b0;
              state_r <= ST_IDLE;
            end
          end
        end
        ST_READ: begin
          if (mem_ack) begin
            buf_r       <= mem_rdata;
            buf_addr_r  <= mem_addr;
            buf_valid_r <= 1'b1;
            mem_req     <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Raw-pin read path so half-word toggles need no clock.
  assign bus_data_out = bus_addr[0] ? buf_r[31:16] : buf_r[15:0];
  assign bus_data_oe  = !bus_cs_b & !bus_oe_b & bus_we_b;

endmodule

// File: tb/tb_sram_bus_responder.sv
// Self-checking bench for sram_bus_responder: a memory model acknowledges
// requests and logs them; each test pushes expected transactions to a
// scoreboard queue and pops/compares them against the log.
module tb_sram_bus_responder;

  typedef struct packed {
    logic        rnw;
    logic [16:0] addr;
    logic [31:0] wdata;
    logic [1:0]  mask;
  } txn_t;

  logic        clock = 1'b0;
  logic        reset_b;
  logic        bus_cs_b, bus_oe_b, bus_we_b;
  logic [17:0] bus_addr;
  logic [15:0] bus_data_in;
  logic [15:0] bus_data_out;
  logic        bus_data_oe;
  logic        mem_req, mem_rnw;
  logic [16:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_wmask;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic        overflow;

  logic        ack_en;
  logic [31:0] rdata_val;
  int          req_low_cnt = 0;
  txn_t        exp_q[$];
  txn_t        obs_q[$];
  int          low_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          lat;
  txn_t        e, o;

  sram_bus_responder #(.ASIZE(18), .SYNC(2)) dut (
    .clock(clock), .reset_b(reset_b),
    .bus_cs_b(bus_cs_b), .bus_oe_b(bus_oe_b), .bus_we_b(bus_we_b),
    .bus_addr(bus_addr), .bus_data_in(bus_data_in),
    .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe),
    .mem_req(mem_req), .mem_rnw(mem_rnw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .overflow(overflow)
  );

  always #5 clock = ~clock;

  // Memory model: one-cycle ack per request, logs each accepted transaction.
  always @(negedge clock) begin
    if (!mem_req) req_low_cnt = req_low_cnt + 1;
    if (mem_req && !mem_ack && ack_en) begin
      mem_ack   = 1'b1;
      mem_rdata = rdata_val;
      obs_q.push_back({mem_rnw, mem_addr, mem_rnw ? 32'h0 : mem_wdata, mem_rnw ? 2'b00 : mem_wmask});
      low_q.push_back(req_low_cnt);
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
    end
  end

  task automatic bus_write(input logic [17:0] a, input logic [15:0] d, output int l);
    l = 0;
    @(negedge clock);
    bus_addr = a; bus_data_in = d; bus_cs_b = 1'b0; bus_we_b = 1'b0;
    repeat (2) @(negedge clock);
    bus_we_b = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clock);
      if (mem_req && l == 0) l = i;
    end
    bus_cs_b = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic bus_read(input logic [17:0] a);
    @(negedge clock);
    bus_addr = a; bus_cs_b = 1'b0; bus_oe_b = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  task automatic bus_idle();
    bus_cs_b = 1'b1; bus_oe_b = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic wait_obs(input int n);
    for (int i = 0; i < 100 && obs_q.size() < n; i++) @(negedge clock);
    repeat (10) @(negedge clock);
  endtask

  task automatic test_reset();
    reset_b = 1'b0;
    repeat (3) @(negedge clock);
    total_cnt++; if (mem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", mem_req); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow); else pass_cnt++;
    total_cnt++; if (bus_data_out !== 16'h0) $display("FAIL reset_dout: got %h want 0000", bus_data_out); else pass_cnt++;
    total_cnt++; if (mem_wmask !== 2'b00) $display("FAIL reset_mask: got %b want 00", mem_wmask); else pass_cnt++;
    total_cnt++; if (bus_data_oe !== 1'b0) $display("FAIL reset_oe: got %b want 0", bus_data_oe); else pass_cnt++;
    reset_b = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_write_pair();
    exp_q.push_back({1'b0, 17'h00008, 32'h5678_1234, 2'b11});
    bus_write(18'h00010, 16'h1234, lat);
    bus_write(18'h00011, 16'h5678, lat);
    wait_obs(1);
    total_cnt++; if (obs_q.size() !== 1) $display("FAIL pair_count: got %0d want 1", obs_q.size()); else pass_cnt++;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); total_cnt++;
      if (obs_q.size() == 0) $display("FAIL pair_txn: got none want %h", e);
      else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL pair_txn: got %h want %h", o, e); else pass_cnt++; end
    end
  endtask

  task automatic test_high_only();
    exp_q.push_back({1'b0, 17'h00010, 32'hBEEF_0000, 2'b10});
    bus_write(18'h00021, 16'hBEEF, lat);
    total_cnt++; if (lat !== 3) $display("FAIL high_latency: got %0d want 3", lat); else pass_cnt++;
    wait_obs(1);
    total_cnt++; if (obs_q.size() !== 1) $display("FAIL high_count: got %0d want 1", obs_q.size()); else pass_cnt++;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); total_cnt++;
      if (obs_q.size() == 0) $display("FAIL high_txn: got none want %h", e);
      else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL high_txn: got %h want %h", o, e); else pass_cnt++; end
    end
  endtask

  task automatic test_low_flush();
    exp_q.push_back({1'b0, 17'h00020, 32'h0000_AAAA, 2'b01});
    exp_q.push_back({1'b0, 17'h00028, 32'h7777_5555, 2'b11});
    bus_write(18'h00040, 16'hAAAA, lat);
    bus_write(18'h00050, 16'h5555, lat);
    bus_write(18'h00051, 16'h7777, lat);
    wait_obs(2);
    total_cnt++; if (obs_q.size() !== 2) $display("FAIL flush_count: got %0d want 2", obs_q.size()); else pass_cnt++;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); total_cnt++;
      if (obs_q.size() == 0) $display("FAIL flush_txn: got none want %h", e);
      else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL flush_txn: got %h want %h", o, e); else pass_cnt++; end
    end
  endtask

  task automatic test_back_to_back();
    int l0, l1;
    low_q.delete();
    exp_q.push_back({1'b0, 17'h00038, 32'h0000_1111, 2'b01});
    exp_q.push_back({1'b0, 17'h00040, 32'h2222_0000, 2'b10});
    bus_write(18'h00070, 16'h1111, lat);
    bus_write(18'h00081, 16'h2222, lat);
    wait_obs(2);
    l0 = (low_q.size() > 0) ? low_q[0] : -1;
    l1 = (low_q.size() > 1) ? low_q[1] : -2;
    total_cnt++; if (l1 !== l0) $display("FAIL b2b_gap: idle cycles between got %0d want 0", l1 - l0); else pass_cnt++;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); total_cnt++;
      if (obs_q.size() == 0) $display("FAIL b2b_txn: got none want %h", e);
      else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL b2b_txn: got %h want %h", o, e); else pass_cnt++; end
    end
  endtask

  task automatic test_read();
    rdata_val = 32'hCAFE_F00D;
    exp_q.push_back({1'b1, 17'h00030, 32'h0, 2'b00});
    bus_read(18'h00060);
    total_cnt++; if (bus_data_out !== 16'hF00D) $display("FAIL read_lo: got %h want F00D", bus_data_out); else pass_cnt++;
    total_cnt++; if (bus_data_oe !== 1'b1) $display("FAIL read_oe_on: got %b want 1", bus_data_oe); else pass_cnt++;
    bus_addr = 18'h00061;
    #1;
    total_cnt++; if (bus_data_out !== 16'hCAFE) $display("FAIL read_hi: got %h want CAFE", bus_data_out); else pass_cnt++;
    wait_obs(1);
    total_cnt++; if (obs_q.size() !== 1) $display("FAIL read_count: got %0d want 1", obs_q.size()); else pass_cnt++;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); total_cnt++;
      if (obs_q.size() == 0) $display("FAIL read_txn: got none want %h", e);
      else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL read_txn: got %h want %h", o, e); else pass_cnt++; end
    end
    bus_oe_b = 1'b1;
    #1;
    total_cnt++; if (bus_data_oe !== 1'b0) $display("FAIL read_oe_off: got %b want 0", bus_data_oe); else pass_cnt++;
    bus_idle();
    // A high write to the buffered word must update the buffer.
    exp_q.push_back({1'b0, 17'h00030, 32'h1357_0000, 2'b10});
    bus_write(18'h00061, 16'h1357, lat);
    wait_obs(1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); total_cnt++;
      if (obs_q.size() == 0) $display("FAIL coh_txn: got none want %h", e);
      else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL coh_txn: got %h want %h", o, e); else pass_cnt++; end
    end
    bus_read(18'h00061);
    repeat (5) @(negedge clock);
    total_cnt++; if (bus_data_out !== 16'h1357) $display("FAIL coh_hi: got %h want 1357", bus_data_out); else pass_cnt++;
    total_cnt++; if (obs_q.size() !== 0) $display("FAIL coh_hit: got %0d reads want 0", obs_q.size()); else pass_cnt++;
    bus_addr = 18'h00060;
    #1;
    total_cnt++; if (bus_data_out !== 16'hF00D) $display("FAIL coh_lo: got %h want F00D", bus_data_out); else pass_cnt++;
    bus_idle();
  endtask

  task automatic test_overflow();
    ack_en = 1'b0;
    exp_q.push_back({1'b0, 17'h00080, 32'hA1A1_A0A0, 2'b11});
    bus_write(18'h00100, 16'hA0A0, lat);
    bus_write(18'h00101, 16'hA1A1, lat);
    bus_write(18'h00200, 16'hB0B0, lat);
    bus_write(18'h00201, 16'hB1B1, lat);
    bus_write(18'h00300, 16'hC0C0, lat);
    bus_write(18'h00301, 16'hC1C1, lat);
    total_cnt++; if (mem_req !== 1'b1) $display("FAIL ovf_req_held: got %b want 1", mem_req); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow); else pass_cnt++;
    ack_en = 1'b1;
    wait_obs(1);
    total_cnt++; if (obs_q.size() !== 1) $display("FAIL ovf_count: got %0d want 1", obs_q.size()); else pass_cnt++;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); total_cnt++;
      if (obs_q.size() == 0) $display("FAIL ovf_txn: got none want %h", e);
      else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL ovf_txn: got %h want %h", o, e); else pass_cnt++; end
    end
    repeat (10) @(negedge clock);
    total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    ack_en = 1'b0;
    bus_write(18'h00401, 16'h4444, lat);
    for (int i = 0; i < 20 && !mem_req; i++) @(negedge clock);
    total_cnt++; if (mem_req !== 1'b1) $display("FAIL mid_req_up: got %b want 1", mem_req); else pass_cnt++;
    #2 reset_b = 1'b0;
    #1;
    total_cnt++; if (mem_req !== 1'b0) $display("FAIL mid_req_drop: got %b want 0", mem_req); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL mid_ovf_clr: got %b want 0", overflow); else pass_cnt++;
    repeat (2) @(negedge clock);
    reset_b = 1'b1;
    obs_q.delete();
    ack_en = 1'b1;
    repeat (2) @(negedge clock);
    exp_q.push_back({1'b0, 17'h00280, 32'h5B5B_5A5A, 2'b11});
    bus_write(18'h00500, 16'h5A5A, lat);
    bus_write(18'h00501, 16'h5B5B, lat);
    wait_obs(1);
    total_cnt++; if (obs_q.size() !== 1) $display("FAIL mid_count: got %0d want 1", obs_q.size()); else pass_cnt++;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); total_cnt++;
      if (obs_q.size() == 0) $display("FAIL mid_txn: got none want %h", e);
      else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL mid_txn: got %h want %h", o, e); else pass_cnt++; end
    end
    total_cnt++; if (overflow !== 1'b0) $display("FAIL mid_ovf_after: got %b want 0", overflow); else pass_cnt++;
  endtask

  initial begin
    bus_cs_b = 1'b1; bus_oe_b = 1'b1; bus_we_b = 1'b1;
    bus_addr = 18'h0; bus_data_in = 16'h0;
    reset_b = 1'b0; ack_en = 1'b1; rdata_val = 32'h0;
    test_reset();
    test_write_pair();
    test_high_only();
    test_low_flush();
    test_back_to_back();
    test_read();
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
